// File: rtl/control_fsm.sv
// -----------------------------------------------------------------------------
// control_fsm
// Multicycle RV32I control unit for datapath_main. Moore FSM that steps each
// instruction through FETCH / DECODE / EXECUTE / MEM / WB and drives every
// datapath enable and mux select. One instruction in flight at a time.
//
// Optional feature macro: CTRL_HALT_ON_ILLEGAL_EN
//   defined   : an illegal opcode parks the FSM in a terminal HALT state
//               (halt = 1, all enables 0) until rst is asserted.
//   undefined : an illegal opcode is a NOP, FETCH resumes the next cycle and
//               halt is tied 0.
//
// Ports
//   clk            in   1        system clock, rising edge
//   rst            in   1        asynchronous active-high reset
//   opcode         in   7        inst[6:0]
//   funct3         in   3        inst[14:12]
//   funct7         in   7        inst[31:25] (only bit 5 is meaningful here)
//   zero_flag      in   1        ALU result == 0
//   alu_lt         in   1        ALU less-than
//   adr_src        out  1        0 = PC, 1 = out_bus
//   pc_write       out  1        PC load enable
//   ir_write       out  1        IR / old-PC load enable
//   mem_write      out  1        memory write enable
//   reg_write      out  1        register-file write enable
//   output_en      out  1        output buffer enable (tracks reg_write)
//   out_mux_sel    out  3        0 alu_reg, 1 alu_out, 2 data_reg
//   imm_sel        out  3        0 I, 1 S, 2 B, 3 U, 4 J
//   alu_src_a_sel  out  2        0 old PC, 1 PC, 2 A reg
//   alu_src_b_sel  out  2        0 B reg, 1 imm, 2 const 4
//   alu_ctrl       out  4        ALU operation code
//   halt           out  1        core halted
//   dbg_state      out  STATE_W  current state encoding
//
// State table
//   state    | meaning
//   FETCH    | read IR at PC, PC <= PC + 4
//   DECODE   | alu_reg <= old PC + imm (branch/JAL target), dispatch
//   MEMADR   | effective address = A + imm
//   MEMRD    | read memory at computed address
//   MEMWB    | write loaded data to rd
//   MEMWR    | write B to memory at computed address
//   EXECR    | register-register ALU op
//   EXECI    | register-immediate ALU op
//   ALUWB    | write ALU result register to rd
//   BRANCH   | compare A/B, load PC with target if taken
//   JAL      | PC <= target, compute link old PC + 4
//   JALR1    | compute A + imm target
//   JALR2    | PC <= target, compute link old PC + 4
//   LUI      | pass U immediate
//   AUIPC    | old PC + U immediate
//   ILLEGAL  | unrecognised opcode
//   HALT     | terminal halt (feature build only)
// -----------------------------------------------------------------------------
module control_fsm #(
    parameter int STATE_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic               zero_flag,
    input  logic               alu_lt,
    output logic               adr_src,
    output logic               pc_write,
    output logic               ir_write,
    output logic               mem_write,
    output logic               reg_write,
    output logic               output_en,
    output logic [2:0]         out_mux_sel,
    output logic [2:0]         imm_sel,
    output logic [1:0]         alu_src_a_sel,
    output logic [1:0]         alu_src_b_sel,
    output logic [3:0]         alu_ctrl,
    output logic               halt,
    output logic [STATE_W-1:0] dbg_state
);

    localparam logic [STATE_W-1:0] S_FETCH   = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE  = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR  = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMRD   = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB   = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWR   = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXECR   = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_EXECI   = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_ALUWB   = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_BRANCH  = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_JAL     = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_JALR1   = STATE_W'(11);
    localparam logic [STATE_W-1:0] S_JALR2   = STATE_W'(12);
    localparam logic [STATE_W-1:0] S_LUI     = STATE_W'(13);
    localparam logic [STATE_W-1:0] S_AUIPC   = STATE_W'(14);
    localparam logic [STATE_W-1:0] S_ILLEGAL = STATE_W'(15);
    localparam logic [STATE_W-1:0] S_HALT    = STATE_W'(16);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_AND   = 4'h2;
    localparam logic [3:0] ALU_OR    = 4'h3;
    localparam logic [3:0] ALU_XOR   = 4'h4;
    localparam logic [3:0] ALU_SLL   = 4'h5;
    localparam logic [3:0] ALU_SRL   = 4'h6;
    localparam logic [3:0] ALU_SRA   = 4'h7;
    localparam logic [3:0] ALU_SLT   = 4'h8;
    localparam logic [3:0] ALU_SLTU  = 4'h9;
    localparam logic [3:0] ALU_PASSB = 4'hA;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] SRCA_OLDPC = 2'd0;
    localparam logic [1:0] SRCA_PC    = 2'd1;
    localparam logic [1:0] SRCA_AREG  = 2'd2;
    localparam logic [1:0] SRCB_BREG  = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] SRCB_FOUR  = 2'd2;

    localparam logic [2:0] OUT_ALUREG = 3'd0;
    localparam logic [2:0] OUT_ALUOUT = 3'd1;
    localparam logic [2:0] OUT_DATA   = 3'd2;

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic [3:0]         w_alu_r;
    logic [3:0]         w_alu_i;
    logic [3:0]         w_alu_br;
    logic               w_br_taken;
    logic [2:0]         w_imm_sel;
    logic               w_unused_funct7;

    // Only funct7[5] selects SUB/SRA; the other bits carry no control meaning.
    assign w_unused_funct7 = &{1'b0, funct7[6], funct7[4:0]};

    // funct3 -> ALU op; alt selects SUB over ADD and SRA over SRL.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    assign w_alu_r = alu_decode(funct3, funct7[5]);
    // Immediate forms carry imm[11:5] in funct7, so bit 5 is an alt flag only for SRAI.
    assign w_alu_i = alu_decode(funct3, (funct3 == 3'b101) && funct7[5]);

    always_comb begin
        w_alu_br = ALU_SUB;
        case (funct3[2:1])
            2'b10:   w_alu_br = ALU_SLT;
            2'b11:   w_alu_br = ALU_SLTU;
            default: w_alu_br = ALU_SUB;
        endcase
    end

    // funct3 010/011 are not branches and are never taken.
    always_comb begin
        w_br_taken = 1'b0;
        case (funct3)
            3'b000:  w_br_taken = zero_flag;
            3'b001:  w_br_taken = !zero_flag;
            3'b100:  w_br_taken = alu_lt;
            3'b101:  w_br_taken = !alu_lt;
            3'b110:  w_br_taken = alu_lt;
            3'b111:  w_br_taken = !alu_lt;
            default: w_br_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_imm_sel = IMM_I;
        case (opcode)
            OP_STORE:        w_imm_sel = IMM_S;
            OP_BRANCH:       w_imm_sel = IMM_B;
            OP_LUI, OP_AUIPC: w_imm_sel = IMM_U;
            OP_JAL:          w_imm_sel = IMM_J;
            default:         w_imm_sel = IMM_I;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                    OP_OP:             w_next_state = S_EXECR;
                    OP_IMM:            w_next_state = S_EXECI;
                    OP_BRANCH:         w_next_state = S_BRANCH;
                    OP_JAL:            w_next_state = S_JAL;
                    OP_JALR:           w_next_state = S_JALR1;
                    OP_LUI:            w_next_state = S_LUI;
                    OP_AUIPC:          w_next_state = S_AUIPC;
                    default:           w_next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR: w_next_state = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next_state = S_MEMWB;
            S_MEMWB:  w_next_state = S_FETCH;
            S_MEMWR:  w_next_state = S_FETCH;
            S_EXECR:  w_next_state = S_ALUWB;
            S_EXECI:  w_next_state = S_ALUWB;
            S_ALUWB:  w_next_state = S_FETCH;
            S_BRANCH: w_next_state = S_FETCH;
            S_JAL:    w_next_state = S_ALUWB;
            S_JALR1:  w_next_state = S_JALR2;
            S_JALR2:  w_next_state = S_ALUWB;
            S_LUI:    w_next_state = S_ALUWB;
            S_AUIPC:  w_next_state = S_ALUWB;
`ifdef CTRL_HALT_ON_ILLEGAL_EN
            S_ILLEGAL: w_next_state = S_HALT;
            S_HALT:    w_next_state = S_HALT;
`else
            S_ILLEGAL: w_next_state = S_FETCH;
            S_HALT:    w_next_state = S_FETCH;
`endif
            default:  w_next_state = S_FETCH;
        endcase
    end

    // Output decode. rst forces everything to 0 so that an instruction
    // aborted by reset cannot complete a write while rst is high, and so the
    // FETCH state held during reset does not load PC/IR.
    always_comb begin
        adr_src       = 1'b0;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        out_mux_sel   = OUT_ALUREG;
        imm_sel       = IMM_I;
        alu_src_a_sel = SRCA_OLDPC;
        alu_src_b_sel = SRCB_BREG;
        alu_ctrl      = ALU_ADD;
        halt          = 1'b0;
        if (!rst) begin
            imm_sel = w_imm_sel;
            case (r_state)
                S_FETCH: begin
                    ir_write      = 1'b1;
                    pc_write      = 1'b1;
                    alu_src_a_sel = SRCA_PC;
                    alu_src_b_sel = SRCB_FOUR;
                    out_mux_sel   = OUT_ALUOUT;
                end
                S_DECODE: begin
                    alu_src_a_sel = SRCA_OLDPC;
                    alu_src_b_sel = SRCB_IMM;
                end
                S_MEMADR, S_JALR1: begin
                    alu_src_a_sel = SRCA_AREG;
                    alu_src_b_sel = SRCB_IMM;
                end
                S_MEMRD: begin
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    out_mux_sel = OUT_DATA;
                    reg_write   = 1'b1;
                end
                S_MEMWR: begin
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXECR: begin
                    alu_src_a_sel = SRCA_AREG;
                    alu_src_b_sel = SRCB_BREG;
                    alu_ctrl      = w_alu_r;
                end
                S_EXECI: begin
                    alu_src_a_sel = SRCA_AREG;
                    alu_src_b_sel = SRCB_IMM;
                    alu_ctrl      = w_alu_i;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a_sel = SRCA_AREG;
                    alu_src_b_sel = SRCB_BREG;
                    alu_ctrl      = w_alu_br;
                    pc_write      = w_br_taken;
                end
                S_JAL, S_JALR2: begin
                    // PC takes the target held in alu_reg while the ALU
                    // forms the link value for the following ALUWB.
                    pc_write      = 1'b1;
                    alu_src_a_sel = SRCA_OLDPC;
                    alu_src_b_sel = SRCB_FOUR;
                end
                S_LUI: begin
                    alu_src_b_sel = SRCB_IMM;
                    alu_ctrl      = ALU_PASSB;
                end
                S_AUIPC: begin
                    alu_src_a_sel = SRCA_OLDPC;
                    alu_src_b_sel = SRCB_IMM;
                end
`ifdef CTRL_HALT_ON_ILLEGAL_EN
                S_HALT: begin
                    halt = 1'b1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign output_en = reg_write;
    assign dbg_state = r_state;

endmodule
